dec_arb: RTL
============

DEC_ARB -- requirements
Module: dec_arb

Interface
REQ-001 Parameter DATAWIDTH, default 32, operand/result width in bits.
REQ-002 Parameter NUM_REQ, fixed at 4; number of requesters sharing one decrementer.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 req  input  4  per-requester request; bit i asserted while requester i has an operand pending.
REQ-006 a_in  input  4*DATAWIDTH  packed operands; slice [i*DATAWIDTH +: DATAWIDTH] belongs to requester i.
REQ-007 gnt  output  4  one-hot grant; combinational; bit i high in the cycle requester i's operand is accepted.
REQ-008 d_ready  input  1  downstream ready for result.
REQ-009 d_valid  output  1  registered; result register holds an unconsumed result.
REQ-010 d_out  output  DATAWIDTH  registered result, operand minus 1.
REQ-011 d_id  output  2  registered index of the requester that produced d_out.
REQ-012 proto_err  output  1  sticky flag for requester protocol violation.
REQ-013 issue_cnt  output  16  registered count of grants issued since reset.

Function
REQ-014 Block SHALL contain exactly one decrementer instance shared by all requesters; operand mux selected by gnt.
REQ-015 Output register SHALL have two states: EMPTY (d_valid=0) and FULL (d_valid=1).
REQ-016 Issue is permitted in a cycle when rst=0 and (state EMPTY, or state FULL with d_ready=1).
REQ-017 When issue is permitted and req!=0, exactly one gnt bit SHALL assert; otherwise gnt=0.
REQ-018 Arbitration SHALL be round-robin: search starts at pointer ptr and proceeds ptr, ptr+1, ... mod 4; first requester with req high wins.
REQ-019 On a grant to requester k, ptr SHALL update to (k+1) mod 4 at the next edge; without a grant ptr holds.
REQ-020 On a grant to k, next edge SHALL load d_out = a_in[k] - 1 (modulo 2^DATAWIDTH), d_id = k, d_valid = 1; latency one cycle from gnt to d_valid.
REQ-021 Operand 0 SHALL wrap to all ones (0xFFFFFFFF for DATAWIDTH=32); no flag raised.
REQ-022 FULL with d_ready=1 and no grant SHALL transition to EMPTY; d_out and d_id hold last value.
REQ-023 FULL with d_ready=1 and a grant (simultaneous drain and issue) SHALL stay FULL with new result loaded; back-to-back throughput one result per cycle.
REQ-024 FULL with d_ready=0 SHALL hold d_out, d_id, d_valid unchanged and gnt=0.
REQ-025 d_ready is ignored in EMPTY.
REQ-026 Requester protocol: req[i] SHALL remain high and a_in slice stable until gnt[i]; req[i] deasserting in a cycle where it was high the previous cycle without a gnt[i] in that previous cycle SHALL set proto_err=1 at next edge.
REQ-027 proto_err SHALL remain 1 until rst; it does not affect arbitration.
REQ-028 issue_cnt SHALL increment by 1 on each grant and wrap 0xFFFF -> 0x0000.
REQ-029 A requester whose req remains high after its grant is treated as a new request and SHALL compete under round-robin.

Reset
REQ-030 With rst=1 at a rising edge: d_valid=0, d_out=0, d_id=0, ptr=0, proto_err=0, issue_cnt=0, state EMPTY.
REQ-031 gnt SHALL be 0 in every cycle rst=1, regardless of req.
REQ-032 Reset mid-operation SHALL discard the pending result without a handshake; requests held across reset are re-arbitrated from ptr=0 after rst falls.
REQ-033 Previous-cycle req sampling for proto_err SHALL clear to 0 on reset; no error flagged for the first cycle after reset.

Verification
REQ-034 Reset then req=4'b0001, a_in[0]=0x00000005, d_ready=1 -> gnt=4'b0001 that cycle; next cycle d_valid=1, d_out=0x00000004, d_id=0, issue_cnt=1.
REQ-035 req=4'b1111 held, all operands distinct, d_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; d_valid continuously 1; each d_out equals its operand minus 1.
REQ-036 a_in[2]=0x00000000, req=4'b0100 -> d_out=0xFFFFFFFF, d_id=2, proto_err=0.
REQ-037 Result FULL, d_ready=0 for 3 cycles with req=4'b0011 -> gnt=0 and d_out stable for 3 cycles; d_ready=1 -> gnt=4'b0001 (ptr) same cycle, new result next cycle.
REQ-038 req[1] high for 1 cycle while stalled (no gnt[1]), then dropped -> proto_err=1 next edge and stays 1 until rst.
REQ-039 rst asserted while FULL with req=4'b1000 -> d_valid=0, gnt=0 during reset; after rst falls, gnt=4'b1000 and issue_cnt restarts at 1.

Source files
------------

// File: rtl/dec_arb.sv
// Round-robin arbiter feeding one shared decrementer into a single-entry result register.
// A new result may be loaded while the previous one drains, so back-to-back issue runs at one per cycle.
module dec_arb #(
  parameter int DATAWIDTH = 32,
  parameter int NUM_REQ   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATAWIDTH-1:0] a_in,
  output logic [NUM_REQ-1:0]           gnt,
  input  logic                         d_ready,
  output logic                         d_valid,
  output logic [DATAWIDTH-1:0]         d_out,
  output logic [1:0]                   d_id,
  output logic                         proto_err,
  output logic [15:0]                  issue_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             ptr_q, ptr_d;
  logic [DATAWIDTH-1:0]   d_out_q, d_out_d;
  logic [1:0]             d_id_q, d_id_d;
  logic                   proto_err_q, proto_err_d;
  logic [15:0]            issue_cnt_q, issue_cnt_d;
  logic [NUM_REQ-1:0]     req_prev_q, req_prev_d;
  logic [NUM_REQ-1:0]     gnt_prev_q, gnt_prev_d;

  logic                   issue_ok;
  logic                   found;
  logic [1:0]             gnt_idx;
  logic [1:0]             idx;
  logic [DATAWIDTH-1:0]   operand;
  logic [DATAWIDTH-1:0]   dec_res;

  assign issue_ok = !rst && ((state_q == EMPTY) || d_ready);

  // Rotating priority search starting at ptr_q; 2-bit index wraps mod 4.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    if (issue_ok) begin
      for (int o = 0; o < NUM_REQ; o++) begin
        idx = ptr_q + o[1:0];
        if (!found && req[idx]) begin
          found      = 1'b1;
          gnt[idx]   = 1'b1;
          gnt_idx    = idx;
        end
      end
    end
  end

  // Single shared decrementer behind a one-hot operand mux.
  always_comb begin
    operand = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) operand = operand | a_in[i*DATAWIDTH +: DATAWIDTH];
    dec_res = operand - DATAWIDTH'(1);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    d_out_d     = d_out_q;
    d_id_d      = d_id_q;
    issue_cnt_d = issue_cnt_q;
    proto_err_d = proto_err_q | (|(req_prev_q & ~gnt_prev_q & ~req));
    req_prev_d  = req;
    gnt_prev_d  = gnt;
    case (state_q)
      EMPTY: if (found) state_d = FULL;
      FULL:  if (d_ready && !found) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (found) begin
      ptr_d       = gnt_idx + 2'd1;
      d_out_d     = dec_res;
      d_id_d      = gnt_idx;
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      ptr_q       <= '0;
      d_out_q     <= '0;
      d_id_q      <= '0;
      proto_err_q <= 1'b0;
      issue_cnt_q <= '0;
      req_prev_q  <= '0;
      gnt_prev_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      d_out_q     <= d_out_d;
      d_id_q      <= d_id_d;
      proto_err_q <= proto_err_d;
      issue_cnt_q <= issue_cnt_d;
      req_prev_q  <= req_prev_d;
      gnt_prev_q  <= gnt_prev_d;
    end
  end

  assign d_valid   = (state_q == FULL);
  assign d_out     = d_out_q;
  assign d_id      = d_id_q;
  assign proto_err = proto_err_q;
  assign issue_cnt = issue_cnt_q;

endmodule
